// File: rtl/if_pkg.sv
// Shared types and default parameter values for the instruction-fetch unit.
package if_pkg;

  // Fetch FSM: IDLE may issue, WAIT expects data to keep, DROP expects data to discard.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

  localparam int unsigned DEF_ADDR_W   = 16;
  localparam int unsigned DEF_INSTR_W  = 16;
  localparam int unsigned DEF_PC_INC   = 2;
  localparam int unsigned DEF_DEPTH    = 4;
  localparam int unsigned DEF_RESET_PC = 0;

endpackage : if_pkg

// File: rtl/if_fifo.sv
// Synchronous prefetch FIFO with flush; DEPTH must be a power of two, >= 2.
module if_fifo
  import if_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_INSTR_W + DEF_ADDR_W,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  // Next pointers and occupancy; flush empties the buffer in one cycle.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    // NOTE: storage has no reset; an entry is only ever read after it was written, and count gates validity.
    if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

endmodule : if_fifo

// File: rtl/if_unit_pf.sv
// Instruction fetch unit with a prefetch buffer and a single outstanding memory request.
module if_unit_pf
  import if_pkg::*;
#(
  parameter int unsigned       ADDR_W   = DEF_ADDR_W,
  parameter int unsigned       INSTR_W  = DEF_INSTR_W,
  parameter int unsigned       PC_INC   = DEF_PC_INC,
  parameter int unsigned       DEPTH    = DEF_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc_out
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned ENT_W = INSTR_W + ADDR_W;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [ENT_W-1:0]  fifo_rdata;
  logic [CNT_W:0]    pending;
  logic              outstanding;

  // An in-flight request already owns a buffer slot, so it counts against capacity.
  assign outstanding = (state_q != S_IDLE);
  assign pending     = {1'b0, fifo_count} + {{CNT_W{1'b0}}, outstanding};
  assign imem_req    = !rst && (state_q == S_IDLE) && !redirect && (pending < (CNT_W + 1)'(DEPTH));
  assign imem_addr   = fetch_pc_q;

  assign fifo_pop    = !fifo_empty && !stall && !redirect;
  assign instr_valid = !fifo_empty;
  assign instr       = fifo_rdata[ADDR_W +: INSTR_W];
  assign pc_out      = fifo_rdata[ADDR_W-1:0] + ADDR_W'(PC_INC);

  // Fetch FSM next-state, fetch PC update and buffer push decision.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    fifo_push  = 1'b0;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      // A response landing in the redirect cycle retires the old request; otherwise it becomes stale.
      case (state_q)
        S_WAIT:  state_d = imem_rvalid ? S_IDLE : S_DROP;
        S_DROP:  state_d = imem_rvalid ? S_IDLE : S_DROP;
        default: state_d = S_IDLE;
      endcase
    end else begin
      case (state_q)
        S_IDLE: begin
          if (imem_req && imem_gnt) begin
            state_d    = S_WAIT;
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + ADDR_W'(PC_INC);
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            fifo_push = !fifo_full || fifo_pop;
            state_d   = S_IDLE;
          end
        end
        S_DROP: begin
          if (imem_rvalid) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM state, fetch PC and address of the outstanding request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
    end
  end

  if_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (redirect),
    .wdata ({imem_rdata, req_pc_q}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule : if_unit_pf
